// File: rtl/fc_120_packer_pkg.sv
// Shared constants and bank-select encoding for the FC-120 input packer.
// Imported by the bank storage and the packer top.
package fc_120_packer_pkg;

    localparam int LENET_BIT_WIDTH = 32;
    localparam int FC120_N_ELEM    = 120;
    localparam int IDX_W           = $clog2(FC120_N_ELEM);

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_e;

    function automatic bank_e other_bank(input bank_e b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/fc_120_pack_bank.sv
// One N_ELEM-word vector buffer, written one word at a time.
// Contents are exposed flattened, element i at bits [BW*(i+1)-1 : BW*i].
module fc_120_pack_bank
    import fc_120_packer_pkg::*;
#(
    parameter int BIT_WIDTH = LENET_BIT_WIDTH,
    parameter int N_ELEM    = FC120_N_ELEM,
    parameter int IW        = $clog2(N_ELEM)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we_i,
    input  logic [IW-1:0]               idx_i,
    input  logic [BIT_WIDTH-1:0]        data_i,
    output logic [BIT_WIDTH*N_ELEM-1:0] flat_o
);

    logic [BIT_WIDTH*N_ELEM-1:0] mem_q;

    // Word storage; cleared by reset so an idle output reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[int'(idx_i)*BIT_WIDTH +: BIT_WIDTH] <= data_i;
        end
    end

    assign flat_o = mem_q;

endmodule

// File: rtl/fc_120_packer.sv
// Ping-pong stream-to-vector packer feeding the 120-neuron FC layer.
// One bank fills from the stream while the other is held for the consumer.
module fc_120_packer
    import fc_120_packer_pkg::*;
#(
    parameter int BIT_WIDTH = LENET_BIT_WIDTH,
    parameter int N_ELEM    = FC120_N_ELEM
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [BIT_WIDTH-1:0]        s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [BIT_WIDTH*N_ELEM-1:0] m_data,
    output logic                        err_len
);

    localparam int IW = $clog2(N_ELEM);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_ELEM - 1);

    logic [IW-1:0] wr_idx_q, wr_idx_d;
    bank_e         wr_bank_q, wr_bank_d;
    bank_e         rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic          err_q, err_d;

    logic accept;
    logic drain;
    logic last_idx;
    logic [BIT_WIDTH*N_ELEM-1:0] flat0, flat1;

    assign s_ready  = !full_q[wr_bank_q];
    assign accept   = s_valid && s_ready;
    assign m_valid  = full_q[rd_bank_q];
    assign drain    = m_valid && m_ready;
    assign last_idx = (wr_idx_q == LAST_IDX);
    assign m_data   = (rd_bank_q == BANK1) ? flat1 : flat0;
    assign err_len  = err_q;

    // Pointer/flag next state; a commit and a drain always hit different banks.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        err_d     = 1'b0;
        if (drain) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = other_bank(rd_bank_q);
        end
        if (accept) begin
            if (last_idx) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = other_bank(wr_bank_q);
                wr_idx_d          = '0;
                err_d             = !s_last;
            end else if (s_last) begin
                wr_idx_d = '0;
                err_d    = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q  <= '0;
            wr_bank_q <= BANK0;
            rd_bank_q <= BANK0;
            full_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            err_q     <= err_d;
        end
    end

    fc_120_pack_bank #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_ELEM    (N_ELEM)
    ) u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept && (wr_bank_q == BANK0)),
        .idx_i  (wr_idx_q),
        .data_i (s_data),
        .flat_o (flat0)
    );

    fc_120_pack_bank #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_ELEM    (N_ELEM)
    ) u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept && (wr_bank_q == BANK1)),
        .idx_i  (wr_idx_q),
        .data_i (s_data),
        .flat_o (flat1)
    );

endmodule
